// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: address/pointer/count width derivations and default
// flag thresholds, intended for reuse by future async and multi-channel FIFOs.
package fifo_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_AE_LEVEL = 2;
  localparam int DEF_AF_GAP   = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

  // One extra wrap bit distinguishes full from empty when the low bits match.
  function automatic int ptr_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic int def_af_level(input int depth);
    return depth - DEF_AF_GAP;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer-side bundle of the synchronous FIFO: write, read,
// flush/error-clear controls and all status outputs.
interface sync_fifo_flags_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) ();

  localparam int CW = cnt_width(DEPTH);

  logic             flush;
  logic             we;
  logic [WIDTH-1:0] d_in;
  logic             re;
  logic             clr_err;
  logic [WIDTH-1:0] d_out;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, we, d_in, re, clr_err,
    input  d_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, we, d_in, re, clr_err,
    output d_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage array: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset.
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/empty thresholds, sticky overflow/underflow and flush.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = def_af_level(DEPTH),
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic              clk,
  input  logic              rst,
  sync_fifo_flags_if.slave  bus
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] AF_CNT = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_CNT = PW'(AE_LEVEL);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $fatal(1, "sync_fifo_flags: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $fatal(1, "sync_fifo_flags: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "sync_fifo_flags: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [WIDTH-1:0] r_d_out;
  logic             r_rd_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic [PW-1:0]    w_count;
  logic             w_wa;
  logic             w_ra;
  logic             w_ovf_evt;
  logic             w_udf_evt;
  logic [WIDTH-1:0] w_rdata;

  // Status comes only from registered pointers, never from we/re directly.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_count = r_wptr - r_rptr;

  assign w_wa      = bus.we & ~w_full  & ~bus.flush;
  assign w_ra      = bus.re & ~w_empty & ~bus.flush;
  assign w_ovf_evt = bus.we & w_full  & ~bus.flush;
  assign w_udf_evt = bus.re & w_empty & ~bus.flush;

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wa),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (bus.d_in),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_d_out     <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_wa) r_wptr <= r_wptr + PW'(1);
        if (w_ra) r_rptr <= r_rptr + PW'(1);
      end

      r_rd_valid <= w_ra;
      if (w_ra) r_d_out <= w_rdata;

      // A new error event outranks a coincident clear.
      if (w_ovf_evt)        r_overflow <= 1'b1;
      else if (bus.clr_err) r_overflow <= 1'b0;

      if (w_udf_evt)        r_underflow <= 1'b1;
      else if (bus.clr_err) r_underflow <= 1'b0;
    end
  end

  assign bus.d_out        = r_d_out;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (w_count >= AF_CNT);
  assign bus.almost_empty = (w_count <= AE_CNT);
  assign bus.count        = w_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench for sync_fifo_flags (WIDTH=8, DEPTH=16, AF=14, AE=2).
module tb_sync_fifo_flags;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];

  sync_fifo_flags_if #(.WIDTH(8), .DEPTH(16)) bus ();

  sync_fifo_flags #(
    .WIDTH    (8),
    .DEPTH    (16),
    .AF_LEVEL (14),
    .AE_LEVEL (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: every rd_valid pulse must match the oldest expected read.
  always @(posedge clk) begin
    #1;
    if (bus.rd_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL rd_data: actual=0x%0h required=no read", bus.d_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.d_out !== e) begin
          n_errors++;
          $display("FAIL rd_data: actual=0x%0h required=0x%0h", bus.d_out, e);
        end else begin
          $display("ok   rd_data: 0x%0h", bus.d_out);
        end
      end
    end
  end

  // One clock of stimulus; returns 1 time unit after the rising edge.
  task automatic cyc(input bit w, input logic [7:0] d, input bit r,
                     input bit f = 1'b0, input bit c = 1'b0);
    bit wa, ra;
    @(negedge clk);
    bus.we = w; bus.d_in = d; bus.re = r; bus.flush = f; bus.clr_err = c;
    wa = w && !f && (model_q.size() < 16);
    ra = r && !f && (model_q.size() > 0);
    if (ra) exp_q.push_back(model_q.pop_front());
    if (wa) model_q.push_back(d);
    if (f) model_q.delete();
    @(posedge clk);
    #1;
    bus.we = 1'b0; bus.re = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    bus.we = 1'b0; bus.re = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;
    bus.d_in = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    chk("reset_empty", int'(bus.empty), 1);
    chk("reset_almost_empty", int'(bus.almost_empty), 1);
    chk("reset_full", int'(bus.full), 0);
    chk("reset_almost_full", int'(bus.almost_full), 0);
    chk("reset_count", int'(bus.count), 0);
    chk("reset_d_out", int'(bus.d_out), 0);
    chk("reset_rd_valid", int'(bus.rd_valid), 0);
    chk("reset_errs", int'({bus.overflow, bus.underflow}), 0);

    // Fill 0x00..0x0F.
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      chk("fill_count", int'(bus.count), i + 1);
      if (i == 1)  chk("fill2_almost_empty", int'(bus.almost_empty), 1);
      if (i == 2)  chk("fill3_almost_empty", int'(bus.almost_empty), 0);
      if (i == 12) chk("fill13_almost_full", int'(bus.almost_full), 0);
      if (i == 13) chk("fill14_almost_full", int'(bus.almost_full), 1);
      if (i == 14) chk("fill15_full", int'(bus.full), 0);
    end
    chk("fill16_full", int'(bus.full), 1);

    cyc(1'b1, 8'hAA, 1'b0);
    chk("write17_overflow", int'(bus.overflow), 1);
    chk("write17_count", int'(bus.count), 16);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_overflow", int'(bus.overflow), 0);

    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("drain_empty", int'(bus.empty), 1);
    chk("drain_count", int'(bus.count), 0);

    cyc(1'b0, 8'h00, 1'b1);
    chk("empty_read_underflow", int'(bus.underflow), 1);
    chk("empty_read_rd_valid", int'(bus.rd_valid), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_underflow", int'(bus.underflow), 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("set_beats_clr", int'(bus.underflow), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Steady streaming at count=5 across pointer wraps.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h50 + 8'(i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 8'h80 + 8'(i), 1'b1);
      chk("stream_count", int'(bus.count), 5);
    end

    for (int i = 0; i < 11; i++) cyc(1'b1, 8'hB0 + 8'(i), 1'b0);
    chk("refill_full", int'(bus.full), 1);
    cyc(1'b1, 8'hEE, 1'b1);
    chk("full_rw_count", int'(bus.count), 15);
    chk("full_rw_overflow", int'(bus.overflow), 1);
    for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("drain2_empty", int'(bus.empty), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Flush at count=9, with we/re also high to show flush wins.
    for (int i = 0; i < 9; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b0);
    chk("preflush_count", int'(bus.count), 9);
    cyc(1'b1, 8'h77, 1'b1, 1'b1);
    chk("flush_count", int'(bus.count), 0);
    chk("flush_empty", int'(bus.empty), 1);
    chk("flush_rd_valid", int'(bus.rd_valid), 0);
    cyc(1'b1, 8'hC3, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);

    // Asynchronous reset between edges with count=7.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h40 + 8'(i), 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("prereset_count", int'(bus.count), 7);
    #2;
    rst = 1'b0;
    #1;
    model_q.delete();
    chk("async_count", int'(bus.count), 0);
    chk("async_empty", int'(bus.empty), 1);
    chk("async_d_out", int'(bus.d_out), 0);
    chk("async_rd_valid", int'(bus.rd_valid), 0);
    chk("async_overflow", int'(bus.overflow), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    chk("pending_reads", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
